ahb_master_req_ctrl: RTL and testbench

Master-side request controller that sits directly upstream of the per-slave arbiters. It decodes each master transaction to a target slave and drives that slave arbiter's request line, holding it until the arbiter grants. It counts accepted beats against the burst length, releases the request after the last beat, and stalls the master through its hready_m output while the request is ungranted. There is one instance per master.

---
 rtl/ahb_master_req_ctrl_pkg.sv | 49 ++++
 rtl/ahb_master_req_ctrl_addr_decode.sv | 19 +
 rtl/ahb_master_req_ctrl.sv | 149 ++++++++++++++
 tb/tb_ahb_master_req_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_master_req_ctrl_pkg.sv
// Shared AHB types, controller state encoding and burst-length decode.
package ahb_master_req_ctrl_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_type;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_type;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_GAP
  } state_t;

  // last = index of the final beat; unbounded marks INCR
  typedef struct packed {
    logic       unbounded;
    logic [3:0] last;
  } burst_len_t;

  function automatic burst_len_t burst_len(input hburst_type b);
    burst_len_t r;
    r.unbounded = 1'b0;
    r.last      = 4'd0;
    case (b)
      HB_INCR:              r.unbounded = 1'b1;
      HB_WRAP4,  HB_INCR4:  r.last = 4'd3;
      HB_WRAP8,  HB_INCR8:  r.last = 4'd7;
      HB_WRAP16, HB_INCR16: r.last = 4'd15;
      default:              r.last = 4'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ahb_master_req_ctrl_addr_decode.sv
// Combinational address decode: MSB slice gives the slave index, mapped
// flags indices that have an arbiter behind them.
module ahb_master_req_ctrl_addr_decode #(
  parameter int ADDR_W    = 32,
  parameter int SEL_BIT   = 2,
  parameter int SLAVE_NUM = 4
) (
  input  logic [ADDR_W-1:0]  haddr,
  output logic [SEL_BIT-1:0] idx,
  output logic               mapped
);

  logic unused_low;

  assign idx        = haddr[ADDR_W-1 -: SEL_BIT];
  assign mapped     = (int'(idx) < SLAVE_NUM);
  assign unused_low = ^haddr[ADDR_W-SEL_BIT-1:0];

endmodule

// File: rtl/ahb_master_req_ctrl.sv
// Per-master request controller: decodes the target slave, holds hreq until
// granted, counts burst beats and stalls the master via hready_m.
module ahb_master_req_ctrl
  import ahb_master_req_ctrl_pkg::*;
#(
  parameter int SLAVE_NUM = 4,
  parameter int ADDR_W    = 32,
  parameter int SEL_BIT   = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic [1:0]           htrans,
  input  logic [ADDR_W-1:0]    haddr,
  input  logic [2:0]           hburst,
  input  logic [SLAVE_NUM-1:0] hgrant,
  output logic [SLAVE_NUM-1:0] hreq,
  output logic                 hready_m,
  output logic [SEL_BIT-1:0]   slave_sel,
  output logic                 derr,
  output logic                 timeout
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t               state, state_nxt;
  logic [SEL_BIT-1:0]   sel_nxt;
  burst_len_t           len_r, len_nxt;
  logic [3:0]           beat_cnt, beat_nxt;
  logic [WAIT_W-1:0]    wait_cnt, wait_nxt;
  logic [SLAVE_NUM-1:0] hreq_nxt;
  logic                 hready_nxt, derr_nxt, timeout_nxt;

  logic [SEL_BIT-1:0]   dec_idx;
  logic                 dec_mapped;
  htrans_type           tr;
  logic                 gnt, is_ns, beat_ok, done;

  ahb_master_req_ctrl_addr_decode #(
    .ADDR_W   (ADDR_W),
    .SEL_BIT  (SEL_BIT),
    .SLAVE_NUM(SLAVE_NUM)
  ) u_decode (
    .haddr (haddr),
    .idx   (dec_idx),
    .mapped(dec_mapped)
  );

  assign tr      = htrans_type'(htrans);
  assign gnt     = hgrant[slave_sel];
  assign is_ns   = (tr == HT_NONSEQ);
  assign beat_ok = gnt && (tr == HT_SEQ);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= ST_IDLE;
      slave_sel <= '0;
      len_r     <= '0;
      beat_cnt  <= '0;
      wait_cnt  <= '0;
      hreq      <= '0;
      hready_m  <= 1'b1;
      derr      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      slave_sel <= sel_nxt;
      len_r     <= len_nxt;
      beat_cnt  <= beat_nxt;
      wait_cnt  <= wait_nxt;
      hreq      <= hreq_nxt;
      hready_m  <= hready_nxt;
      derr      <= derr_nxt;
      timeout   <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sel_nxt     = slave_sel;
    len_nxt     = len_r;
    beat_nxt    = beat_cnt;
    wait_nxt    = wait_cnt;
    derr_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    done        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_ns) begin
          if (dec_mapped) begin
            state_nxt = ST_REQ;
            sel_nxt   = dec_idx;
            len_nxt   = burst_len(hburst_type'(hburst));
            wait_nxt  = '0;
          end else begin
            derr_nxt = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (gnt) begin
          beat_nxt  = 4'd1;
          wait_nxt  = '0;
          state_nxt = (!len_r.unbounded && len_r.last == 4'd0) ? ST_IDLE : ST_XFER;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_nxt = 1'b1;
          wait_nxt    = '0;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      ST_XFER: begin
        if (beat_ok) beat_nxt = beat_cnt + 1'b1;
        if (len_r.unbounded) done = (tr == HT_IDLE) || is_ns;
        else                 done = beat_ok && (beat_cnt == len_r.last);
        // a NONSEQ on the completing cycle starts the next request after one GAP cycle
        if (done) begin
          if (is_ns && dec_mapped) begin
            state_nxt = ST_GAP;
            sel_nxt   = dec_idx;
            len_nxt   = burst_len(hburst_type'(hburst));
          end else begin
            state_nxt = ST_IDLE;
            derr_nxt  = is_ns;
          end
        end
      end
      ST_GAP: begin
        state_nxt = ST_REQ;
        wait_nxt  = '0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    hreq_nxt   = '0;
    hready_nxt = 1'b0;
    if (state_nxt == ST_REQ || state_nxt == ST_XFER)
      hreq_nxt = SLAVE_NUM'(1) << sel_nxt;
    case (state_nxt)
      ST_IDLE: hready_nxt = 1'b1;
      ST_XFER: hready_nxt = gnt;
      default: hready_nxt = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Randomized scenario bench for ahb_master_req_ctrl with a transaction-level expectation model.
module tb_ahb_master_req_ctrl;
  import ahb_master_req_ctrl_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [2:0]  hburst;
  logic [3:0]  hgrant;
  logic [3:0]  hreq;
  logic        hready_m;
  logic [1:0]  slave_sel;
  logic        derr;
  logic        timeout;
  logic [2:0]  hreq3;
  logic        hready3;
  logic [1:0]  sel3;
  logic        derr3;
  logic        tmo3;

  int n_chk  = 0;
  int n_pass = 0;

  ahb_master_req_ctrl dut (
    .hclk(hclk), .hreset(hreset), .htrans(htrans), .haddr(haddr), .hburst(hburst),
    .hgrant(hgrant), .hreq(hreq), .hready_m(hready_m), .slave_sel(slave_sel),
    .derr(derr), .timeout(timeout)
  );

  ahb_master_req_ctrl #(.SLAVE_NUM(3)) dut3 (
    .hclk(hclk), .hreset(hreset), .htrans(htrans), .haddr(haddr), .hburst(hburst),
    .hgrant(hgrant[2:0]), .hreq(hreq3), .hready_m(hready3), .slave_sel(sel3),
    .derr(derr3), .timeout(tmo3)
  );

  always #5 hclk = ~hclk;

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_idle();
    htrans = 2'd0;
    hgrant = 4'd0;
    hburst = 3'd0;
    haddr  = $urandom;
  endtask

  task automatic do_reset();
    hreset = 1'b1;
    drive_idle();
    step();
    hreset = 1'b0;
  endtask

  // Beats in a burst, straight from the AHB burst-type table
  function automatic int burst_beats(input logic [2:0] b, input int incr_n);
    case (b)
      3'd0:       return 1;
      3'd1:       return incr_n;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  function automatic logic [3:0] noise(input logic [3:0] keep_out);
    return 4'($urandom) & ~keep_out;
  endfunction

  // One transaction: d ungranted REQ cycles, then beats with random wait states / BUSY.
  // term >= 0 follows it with a SINGLE NONSEQ to slave 'term'.
  task automatic run_burst(input int s, input logic [2:0] b, input int incr_n, input int d,
                           input int busy_at, input int busy_pct, input int wait_pct,
                           input int term, input string name);
    logic [3:0] oh, oh_t;
    int  len, beats, xc;
    bit  unb, busy, g, prev_g;
    oh   = 4'(1 << s);
    oh_t = 4'(1 << ((term < 0) ? 0 : term));
    unb  = (b == 3'd1);
    len  = burst_beats(b, incr_n);
    htrans = 2'd2; haddr = {2'(s), 30'($urandom)}; hburst = b; hgrant = noise(oh);
    step();
    for (int k = 0; k <= d; k++) begin
      n_chk++;
      if (hreq !== oh || hready_m !== 1'b0 || timeout !== 1'b0 || slave_sel !== 2'(s))
        $display("FAIL %s req[%0d]: hreq=%b hready_m=%b timeout=%b sel=%0d, want hreq=%b hready_m=0 timeout=0 sel=%0d",
                 name, k, hreq, hready_m, timeout, slave_sel, oh, s);
      else n_pass++;
      hgrant = noise(oh) | ((k == d) ? oh : 4'b0);
      step();
    end
    beats = 1; prev_g = 1'b1; xc = 0;
    while (beats < len) begin
      n_chk++;
      if (hreq !== oh || hready_m !== prev_g || slave_sel !== 2'(s))
        $display("FAIL %s xfer[%0d]: hreq=%b hready_m=%b sel=%0d, want hreq=%b hready_m=%b sel=%0d",
                 name, xc, hreq, hready_m, slave_sel, oh, prev_g, s);
      else n_pass++;
      busy = (xc == busy_at) || (int'($urandom_range(99)) < busy_pct);
      g    = (int'($urandom_range(99)) >= wait_pct);
      htrans = busy ? 2'd1 : 2'd3;
      hgrant = noise(oh) | (g ? oh : 4'b0);
      if (!busy && g) beats++;
      prev_g = g; xc++;
      step();
    end
    if (!unb) begin
      n_chk++;
      if (hreq !== 4'b0 || hready_m !== 1'b1)
        $display("FAIL %s done: hreq=%b hready_m=%b, want 0000/1", name, hreq, hready_m);
      else n_pass++;
      if (term >= 0) begin
        htrans = 2'd2; haddr = {2'(term), 30'($urandom)}; hburst = 3'd0; hgrant = 4'($urandom);
        step();
      end
    end else begin
      n_chk++;
      if (hreq !== oh || hready_m !== prev_g)
        $display("FAIL %s incr_hold: hreq=%b hready_m=%b, want %b/%b", name, hreq, hready_m, oh, prev_g);
      else n_pass++;
      if (term < 0) htrans = 2'd0;
      else begin
        htrans = 2'd2; haddr = {2'(term), 30'($urandom)}; hburst = 3'd0;
      end
      hgrant = 4'($urandom);
      step();
      n_chk++;
      if (term < 0) begin
        if (hreq !== 4'b0 || hready_m !== 1'b1)
          $display("FAIL %s incr_end: hreq=%b hready_m=%b, want 0000/1", name, hreq, hready_m);
        else n_pass++;
      end else begin
        if (hreq !== 4'b0 || hready_m !== 1'b0 || slave_sel !== 2'(term))
          $display("FAIL %s gap: hreq=%b hready_m=%b sel=%0d, want 0000/0/%0d", name, hreq, hready_m, slave_sel, term);
        else n_pass++;
        hgrant = noise(oh_t);
        step();
      end
    end
    if (term >= 0) begin
      n_chk++;
      if (hreq !== oh_t || hready_m !== 1'b0 || slave_sel !== 2'(term))
        $display("FAIL %s next_req: hreq=%b hready_m=%b sel=%0d, want %b/0/%0d", name, hreq, hready_m, slave_sel, oh_t, term);
      else n_pass++;
      hgrant = noise(oh_t) | oh_t;
      step();
      n_chk++;
      if (hreq !== 4'b0 || hready_m !== 1'b1)
        $display("FAIL %s next_done: hreq=%b hready_m=%b, want 0000/1", name, hreq, hready_m);
      else n_pass++;
    end
    drive_idle();
  endtask

  task automatic test_reset();
    hreset = 1'b1; htrans = 2'd2; haddr = $urandom; hburst = 3'd3; hgrant = 4'hF;
    step();
    n_chk++;
    if (hreq !== 4'b0 || hready_m !== 1'b1 || slave_sel !== 2'd0 || derr !== 1'b0 || timeout !== 1'b0 || dut.state !== ST_IDLE)
      $display("FAIL reset: hreq=%b hready_m=%b sel=%0d derr=%b timeout=%b, want 0000/1/0/0/0", hreq, hready_m, slave_sel, derr, timeout);
    else n_pass++;
    n_chk++;
    if (hreq3 !== 3'b0 || hready3 !== 1'b1 || derr3 !== 1'b0 || tmo3 !== 1'b0 || sel3 !== 2'd0)
      $display("FAIL reset3: hreq=%b hready_m=%b derr=%b, want 000/1/0", hreq3, hready3, derr3);
    else n_pass++;
    hreset = 1'b0;
    drive_idle();
  endtask

  task automatic test_idle_ignores();
    logic [1:0] t;
    for (int i = 0; i < 6; i++) begin
      t = 2'(i % 2 == 0 ? 3 : $urandom_range(1));
      htrans = t; haddr = $urandom; hburst = 3'($urandom); hgrant = 4'($urandom);
      step();
      n_chk++;
      if (hreq !== 4'b0 || hready_m !== 1'b1 || derr !== 1'b0)
        $display("FAIL idle_ignore[%0d]: htrans=%0d hreq=%b hready_m=%b derr=%b, want 0000/1/0", i, t, hreq, hready_m, derr);
      else n_pass++;
    end
    drive_idle();
  endtask

  task automatic test_single();
    run_burst(2, 3'd0, 0, 1, -1, 0, 0, -1, "single_s2");
    for (int i = 0; i < 4; i++)
      run_burst(int'($urandom_range(3)), 3'd0, 0, int'($urandom_range(4)), -1, 0, 0, -1, "single_rand");
  endtask

  task automatic test_incr4_busy();
    run_burst(1, 3'd3, 0, 0, 1, 0, 0, -1, "incr4_busy");
  endtask

  task automatic test_back_to_back();
    run_burst(0, 3'd5, 0, int'($urandom_range(3)), -1, 10, 20, 3, "incr8_b2b");
  endtask

  task automatic test_incr_gap();
    run_burst(int'($urandom_range(3)), 3'd1, int'($urandom_range(20, 17)), 1, -1, 15, 20,
              int'($urandom_range(3)), "incr_gap");
    run_burst(int'($urandom_range(3)), 3'd1, 3, 0, -1, 15, 20, -1, "incr_idle");
  endtask

  task automatic test_random_bursts();
    int s, b, term;
    for (int i = 0; i < 16; i++) begin
      s    = int'($urandom_range(3));
      b    = int'($urandom_range(7));
      term = ($urandom_range(1) == 0) ? -1 : int'($urandom_range(3));
      run_burst(s, 3'(b), int'($urandom_range(20, 1)), int'($urandom_range(4)), -1, 15, 25, term, "random");
    end
  endtask

  task automatic test_timeout();
    logic [3:0] oh;
    int s, pulses;
    bit exp_t;
    s = int'($urandom_range(3)); oh = 4'(1 << s); pulses = 0;
    htrans = 2'd2; haddr = {2'(s), 30'($urandom)}; hburst = 3'd0; hgrant = noise(oh);
    step();
    for (int k = 1; k <= 131; k++) begin
      exp_t = ((k - 1) > 0) && (((k - 1) % 64) == 0);
      if (timeout === 1'b1) pulses++;
      n_chk++;
      if (hreq !== oh || hready_m !== 1'b0 || timeout !== exp_t)
        $display("FAIL timeout[%0d]: hreq=%b hready_m=%b timeout=%b, want %b/0/%b", k, hreq, hready_m, timeout, oh, exp_t);
      else n_pass++;
      hgrant = noise(oh) | ((k == 131) ? oh : 4'b0);
      step();
    end
    n_chk++;
    if (hreq !== 4'b0 || hready_m !== 1'b1 || timeout !== 1'b0 || pulses != 2)
      $display("FAIL timeout_done: hreq=%b hready_m=%b timeout=%b pulses=%0d, want 0000/1/0/2", hreq, hready_m, timeout, pulses);
    else n_pass++;
    drive_idle();
  endtask

  task automatic test_derr();
    do_reset();
    htrans = 2'd2; haddr = {2'd3, 30'($urandom)}; hburst = 3'd0; hgrant = 4'b0;
    step();
    n_chk++;
    if (derr3 !== 1'b1 || hreq3 !== 3'b0 || hready3 !== 1'b1 || hreq !== 4'b1000)
      $display("FAIL derr_pulse: derr=%b hreq=%b hready_m=%b full_hreq=%b, want 1/000/1/1000", derr3, hreq3, hready3, hreq);
    else n_pass++;
    htrans = 2'd0; hgrant = 4'b1000;
    step();
    n_chk++;
    if (derr3 !== 1'b0 || hreq3 !== 3'b0 || hready3 !== 1'b1 || hreq !== 4'b0)
      $display("FAIL derr_clear: derr=%b hreq=%b hready_m=%b full_hreq=%b, want 0/000/1/0000", derr3, hreq3, hready3, hreq);
    else n_pass++;
    // INCR to slave 1 ended by a NONSEQ to the unmapped slave 3
    do_reset();
    htrans = 2'd2; haddr = {2'd1, 30'($urandom)}; hburst = 3'd1; hgrant = 4'b0;
    step();
    hgrant = 4'b0010;
    step();
    htrans = 2'd2; haddr = {2'd3, 30'($urandom)}; hburst = 3'd0; hgrant = 4'b0;
    step();
    n_chk++;
    if (derr3 !== 1'b1 || hreq3 !== 3'b0 || hready3 !== 1'b1)
      $display("FAIL derr_pending: derr=%b hreq=%b hready_m=%b, want 1/000/1", derr3, hreq3, hready3);
    else n_pass++;
    n_chk++;
    if (hreq !== 4'b0 || hready_m !== 1'b0 || slave_sel !== 2'd3)
      $display("FAIL gap_mapped: hreq=%b hready_m=%b sel=%0d, want 0000/0/3", hreq, hready_m, slave_sel);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] oh;
    int s;
    s = int'($urandom_range(3)); oh = 4'(1 << s);
    htrans = 2'd2; haddr = {2'(s), 30'($urandom)}; hburst = 3'd7; hgrant = noise(oh);
    step();
    hgrant = noise(oh) | oh;
    step();
    for (int i = 0; i < 4; i++) begin
      htrans = 2'd3; hgrant = noise(oh) | oh;
      step();
    end
    n_chk++;
    if (dut.beat_cnt !== 4'd5 || hreq !== oh)
      $display("FAIL mid_burst: beat_cnt=%0d hreq=%b, want 5/%b", dut.beat_cnt, hreq, oh);
    else n_pass++;
    hreset = 1'b1; htrans = 2'd3; hgrant = noise(oh) | oh;
    step();
    n_chk++;
    if (hreq !== 4'b0 || hready_m !== 1'b1 || dut.beat_cnt !== 4'd0 || dut.state !== ST_IDLE || slave_sel !== 2'd0)
      $display("FAIL reset_mid: hreq=%b hready_m=%b beat_cnt=%0d sel=%0d, want 0000/1/0/0", hreq, hready_m, dut.beat_cnt, slave_sel);
    else n_pass++;
    hreset = 1'b0;
    drive_idle();
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_ignores();
    test_single();
    test_incr4_busy();
    test_back_to_back();
    test_incr_gap();
    test_random_bursts();
    test_timeout();
    test_derr();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
